cartoon_neighbor_buf: RTL

- Line-buffer stage that sits directly upstream of the cartoon filter.
- Turns the raw VGA pixel stream into the aligned triplet the cartoon filter consumes: centre pixel, right neighbour and down neighbour.
- Buffers one previous line internally and delays the stream so that the "down" pixel, which is in the future relative to the centre, is available.
- Outputs carry centre coordinates and a qualified DE.

---
 rtl/cartoon_neighbor_buf.sv | 129 ++++++++++++
 1 files changed

// File: rtl/cartoon_neighbor_buf.sv
// Line buffer feeding the cartoon filter: emits centre/right/down pixel triplets
// two clocks after the input pixel that completes them (centre = input x-1, y-1).
module cartoon_neighbor_buf #(
    parameter int H_RES = 640,
    parameter int CW    = 4
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          de_in,
    input  logic [9:0]    x_in,
    input  logic [9:0]    y_in,
    input  logic [CW-1:0] r_in,
    input  logic [CW-1:0] g_in,
    input  logic [CW-1:0] b_in,
    output logic          de_out,
    output logic [9:0]    x_out,
    output logic [9:0]    y_out,
    output logic [CW-1:0] r_ctr,
    output logic [CW-1:0] g_ctr,
    output logic [CW-1:0] b_ctr,
    output logic [CW-1:0] r_right,
    output logic [CW-1:0] g_right,
    output logic [CW-1:0] b_right,
    output logic [CW-1:0] r_down,
    output logic [CW-1:0] g_down,
    output logic [CW-1:0] b_down
);
    localparam int         AW     = $clog2(H_RES);
    localparam int         PW     = 3 * CW;
    localparam logic [9:0] H_LIM  = 10'(H_RES);
    localparam logic [9:0] H_LAST = 10'(H_RES - 1);

    logic [PW-1:0] mem [0:H_RES-1];

    logic          accept;
    logic [AW-1:0] addr;
    logic [PW-1:0] pix_in;

    logic [PW-1:0] s1_up_q,   s1_up_d;
    logic [PW-1:0] s1_cur_q,  s1_cur_d;
    logic [9:0]    s1_x_q,    s1_x_d;
    logic [9:0]    s1_y_q,    s1_y_d;
    logic          s1_ok_q,   s1_ok_d;
    logic [PW-1:0] hold_up_q,  hold_up_d;
    logic [PW-1:0] hold_cur_q, hold_cur_d;
    logic [PW-1:0] ctr_q,     ctr_d;
    logic [PW-1:0] right_q,   right_d;
    logic [PW-1:0] down_q,    down_d;
    logic [9:0]    x_out_q,   x_out_d;
    logic [9:0]    y_out_q,   y_out_d;
    logic          de_out_q,  de_out_d;
    logic          line_valid_q, line_valid_d;

    // Out-of-range columns are dropped; the address is parked at 0 so the read stays in bounds.
    assign accept = de_in && (x_in < H_LIM);
    assign addr   = accept ? x_in[AW-1:0] : '0;
    assign pix_in = {r_in, g_in, b_in};

    always_ff @(posedge sys_clk) begin
        if (accept) begin
            mem[addr] <= pix_in;
        end
    end

    always_comb begin
        s1_up_d      = mem[addr];
        s1_cur_d     = pix_in;
        s1_x_d       = x_in;
        s1_y_d       = y_in;
        s1_ok_d      = accept && (x_in != 10'd0) && (y_in != 10'd0) && line_valid_q;
        hold_up_d    = s1_up_q;
        hold_cur_d   = s1_cur_q;
        right_d      = s1_up_q;
        ctr_d        = hold_up_q;
        down_d       = hold_cur_q;
        x_out_d      = s1_x_q - 10'd1;
        y_out_d      = s1_y_q - 10'd1;
        de_out_d     = s1_ok_q;
        line_valid_d = line_valid_q | (accept && (x_in == H_LAST));
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            s1_up_q      <= '0;
            s1_cur_q     <= '0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            s1_ok_q      <= 1'b0;
            hold_up_q    <= '0;
            hold_cur_q   <= '0;
            ctr_q        <= '0;
            right_q      <= '0;
            down_q       <= '0;
            x_out_q      <= '0;
            y_out_q      <= '0;
            de_out_q     <= 1'b0;
            line_valid_q <= 1'b0;
        end else begin
            s1_up_q      <= s1_up_d;
            s1_cur_q     <= s1_cur_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            s1_ok_q      <= s1_ok_d;
            hold_up_q    <= hold_up_d;
            hold_cur_q   <= hold_cur_d;
            ctr_q        <= ctr_d;
            right_q      <= right_d;
            down_q       <= down_d;
            x_out_q      <= x_out_d;
            y_out_q      <= y_out_d;
            de_out_q     <= de_out_d;
            line_valid_q <= line_valid_d;
        end
    end

    assign de_out  = de_out_q;
    assign x_out   = x_out_q;
    assign y_out   = y_out_q;
    assign r_ctr   = ctr_q[PW-1 -: CW];
    assign g_ctr   = ctr_q[2*CW-1 -: CW];
    assign b_ctr   = ctr_q[CW-1:0];
    assign r_right = right_q[PW-1 -: CW];
    assign g_right = right_q[2*CW-1 -: CW];
    assign b_right = right_q[CW-1:0];
    assign r_down  = down_q[PW-1 -: CW];
    assign g_down  = down_q[2*CW-1 -: CW];
    assign b_down  = down_q[CW-1:0];

endmodule
